imm_extend_stage: RTL and testbench

Registered, parametrised immediate extender with a valid/ready handshake on both sides. It widens an IN_W-bit instruction immediate to OUT_W bits in one of four modes: zero-extend, sign-extend, upper-load, or branch-offset. A 2-entry skid buffer lets it sit between a decode stage and an execute stage without breaking the ready path. Accepted immediates emerge in order with 1-cycle latency and full throughput.

---
 rtl/imm_extend_stage_if.sv | 27 ++
 rtl/imm_extend_stage.sv | 111 +++++++++++
 tb/tb_imm_extend_stage.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/imm_extend_stage_if.sv
// Handshake bundle for imm_extend_stage: decode-side input channel,
// execute-side output channel and the synchronous flush.
interface imm_extend_stage_if #(
   parameter int IN_W  = 16,
   parameter int OUT_W = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [IN_W-1:0]  imm;
   logic [1:0]       mode;
   logic             flush;
   logic             out_valid;
   logic             out_ready;
   logic [OUT_W-1:0] out_imm;

   // The extender itself sits on this side.
   modport slave (
      input  in_valid, imm, mode, flush, out_ready,
      output in_ready, out_valid, out_imm
   );

   // Producer/consumer side (decode + execute, or a testbench).
   modport master (
      output in_valid, imm, mode, flush, out_ready,
      input  in_ready, out_valid, out_imm
   );
endinterface

// File: rtl/imm_extend_stage.sv
// Registered immediate extender with a 2-entry skid buffer.
// Widens an IN_W immediate to OUT_W (zero / sign / upper / branch) at the
// input, then stores only the widened value. in_ready comes straight from
// the state register so there is no combinational out_ready -> in_ready path.
// Requires IN_W >= 2 and OUT_W >= IN_W + 2.
module imm_extend_stage #(
   parameter int IN_W  = 16,
   parameter int OUT_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   imm_extend_stage_if.slave bus
);
   localparam int EXT_W = OUT_W - IN_W;

   localparam logic [1:0] ST_EMPTY = 2'd0;
   localparam logic [1:0] ST_ONE   = 2'd1;
   localparam logic [1:0] ST_TWO   = 2'd2;

   localparam logic [1:0] MODE_ZERO   = 2'b00;
   localparam logic [1:0] MODE_SIGN   = 2'b01;
   localparam logic [1:0] MODE_UPPER  = 2'b10;
   localparam logic [1:0] MODE_BRANCH = 2'b11;

   logic [1:0]       state_q, state_d;
   logic [OUT_W-1:0] out_q, out_d;
   logic [OUT_W-1:0] skid_q, skid_d;
   logic [OUT_W-1:0] sext;
   logic [OUT_W-1:0] ext;
   logic             in_ready_o;
   logic             out_valid_o;
   logic             accept;
   logic             xfer;

   // Sign-extended immediate, shared by the sign and branch modes.
   always_comb begin
      sext = {{EXT_W{bus.imm[IN_W-1]}}, bus.imm};
   end

   // Widen the incoming immediate; branch drops the top two sign copies,
   // which is lossless because OUT_W >= IN_W + 2.
   always_comb begin
      ext = '0;
      case (bus.mode)
         MODE_ZERO:   ext = {{EXT_W{1'b0}}, bus.imm};
         MODE_SIGN:   ext = sext;
         MODE_UPPER:  ext = {bus.imm, {EXT_W{1'b0}}};
         MODE_BRANCH: ext = {sext[OUT_W-3:0], 2'b00};
         default:     ext = '0;
      endcase
   end

   assign in_ready_o  = (state_q != ST_TWO);
   assign out_valid_o = (state_q != ST_EMPTY);
   assign accept      = bus.in_valid & in_ready_o;
   assign xfer        = out_valid_o & bus.out_ready;

   assign bus.in_ready  = in_ready_o;
   assign bus.out_valid = out_valid_o;
   assign bus.out_imm   = out_q;

   // Skid-buffer control: output register is the head, skid is the tail.
   // flush wins over everything and leaves the data registers untouched.
   always_comb begin
      state_d = state_q;
      out_d   = out_q;
      skid_d  = skid_q;
      if (bus.flush) begin
         state_d = ST_EMPTY;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (accept) begin
                  state_d = ST_ONE;
                  out_d   = ext;
               end
            end
            ST_ONE: begin
               if (accept && xfer) begin
                  out_d = ext;
               end else if (accept) begin
                  state_d = ST_TWO;
                  skid_d  = ext;
               end else if (xfer) begin
                  state_d = ST_EMPTY;
               end
            end
            ST_TWO: begin
               if (xfer) begin
                  state_d = ST_ONE;
                  out_d   = skid_q;
               end
            end
            default: state_d = ST_EMPTY;
         endcase
      end
   end

   // State and data registers; reset clears both entries asynchronously.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_EMPTY;
         out_q   <= '0;
         skid_q  <= '0;
      end else begin
         state_q <= state_d;
         out_q   <= out_d;
         skid_q  <= skid_d;
      end
   end
endmodule

// File: tb/tb_imm_extend_stage.sv
// Directed + randomized bench for imm_extend_stage: a 16->32 instance for the
// directed scenarios and a 12->20 instance for the random ordering test.
module tb_imm_extend_stage;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   passed = 0;

   always #5 clk = ~clk;

   imm_extend_stage_if #(.IN_W(16), .OUT_W(32)) a_if ();
   imm_extend_stage_if #(.IN_W(12), .OUT_W(20)) b_if ();

   imm_extend_stage #(.IN_W(16), .OUT_W(32)) u_a (.clk(clk), .rst_n(rst_n), .bus(a_if.slave));
   imm_extend_stage #(.IN_W(12), .OUT_W(20)) u_b (.clk(clk), .rst_n(rst_n), .bus(b_if.slave));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #2;
      checks++; if (a_if.in_ready !== 1'b1) $display("FAIL rst_in_ready: got %b want 1", a_if.in_ready); else passed++;
      checks++; if (a_if.out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b want 0", a_if.out_valid); else passed++;
      checks++; if (a_if.out_imm !== 32'h0) $display("FAIL rst_out_imm: got %h want 0", a_if.out_imm); else passed++;
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      checks++; if (a_if.in_ready !== 1'b1) $display("FAIL rel_in_ready: got %b want 1", a_if.in_ready); else passed++;
      checks++; if (a_if.out_valid !== 1'b0) $display("FAIL rel_out_valid: got %b want 0", a_if.out_valid); else passed++;
   endtask

   task automatic test_modes();
      logic [15:0] vimm [6] = '{16'h8001, 16'h8001, 16'h1234, 16'hFFFF, 16'h0003, 16'h7FFF};
      logic [1:0]  vmode[6] = '{2'b01,    2'b00,    2'b10,    2'b11,    2'b11,    2'b01};
      logic [31:0] vexp [6] = '{32'hFFFF8001, 32'h00008001, 32'h12340000,
                                32'hFFFFFFFC, 32'h0000000C, 32'h00007FFF};
      a_if.out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         a_if.in_valid = 1'b1;
         a_if.imm      = vimm[i];
         a_if.mode     = vmode[i];
         tick();
         a_if.in_valid = 1'b0;
         checks++; if (a_if.out_valid !== 1'b1) $display("FAIL mode%0d_valid: got %b want 1", i, a_if.out_valid); else passed++;
         checks++; if (a_if.out_imm !== vexp[i]) $display("FAIL mode%0d_imm: got %h want %h", i, a_if.out_imm, vexp[i]); else passed++;
         tick();
         checks++; if (a_if.out_valid !== 1'b0) $display("FAIL mode%0d_drain: got %b want 0", i, a_if.out_valid); else passed++;
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] vexp[4] = '{32'h00000010, 32'hFFFFFFE0, 32'h00300000, 32'h00000100};
      logic [15:0] vimm[4] = '{16'h0010, 16'hFFE0, 16'h0030, 16'h0040};
      logic [1:0]  vmode[4] = '{2'b00, 2'b01, 2'b10, 2'b11};
      a_if.out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         a_if.in_valid = 1'b1;
         a_if.imm      = vimm[i];
         a_if.mode     = vmode[i];
         tick();
         checks++; if (a_if.out_imm !== vexp[i] || a_if.out_valid !== 1'b1 || a_if.in_ready !== 1'b1)
            $display("FAIL b2b%0d: got v=%b r=%b %h want v=1 r=1 %h", i, a_if.out_valid, a_if.in_ready, a_if.out_imm, vexp[i]);
         else passed++;
      end
      a_if.in_valid = 1'b0;
      tick();
      checks++; if (a_if.out_valid !== 1'b0) $display("FAIL b2b_drain: got %b want 0", a_if.out_valid); else passed++;
   endtask

   task automatic test_backpressure();
      a_if.out_ready = 1'b0;
      a_if.mode      = 2'b00;
      a_if.in_valid  = 1'b1;
      a_if.imm       = 16'h0001;
      checks++; if (a_if.in_ready !== 1'b1) $display("FAIL bp_A_ready: got %b want 1", a_if.in_ready); else passed++;
      tick();
      a_if.imm = 16'h0002;
      checks++; if (a_if.in_ready !== 1'b1 || a_if.out_imm !== 32'h1)
         $display("FAIL bp_B_ready: got r=%b %h want r=1 1", a_if.in_ready, a_if.out_imm);
      else passed++;
      tick();
      a_if.imm = 16'h0003;
      checks++; if (a_if.in_ready !== 1'b0 || a_if.out_imm !== 32'h1)
         $display("FAIL bp_full: got r=%b %h want r=0 1", a_if.in_ready, a_if.out_imm);
      else passed++;
      tick();
      checks++; if (a_if.in_ready !== 1'b0 || a_if.out_imm !== 32'h1 || a_if.out_valid !== 1'b1)
         $display("FAIL bp_hold: got r=%b v=%b %h want r=0 v=1 1", a_if.in_ready, a_if.out_valid, a_if.out_imm);
      else passed++;
      a_if.out_ready = 1'b1;
      tick();
      checks++; if (a_if.out_imm !== 32'h2 || a_if.out_valid !== 1'b1 || a_if.in_ready !== 1'b1)
         $display("FAIL bp_out2: got v=%b r=%b %h want v=1 r=1 2", a_if.out_valid, a_if.in_ready, a_if.out_imm);
      else passed++;
      tick();
      a_if.in_valid = 1'b0;
      checks++; if (a_if.out_imm !== 32'h3 || a_if.out_valid !== 1'b1)
         $display("FAIL bp_out3: got v=%b %h want v=1 3", a_if.out_valid, a_if.out_imm);
      else passed++;
      tick();
      checks++; if (a_if.out_valid !== 1'b0) $display("FAIL bp_empty: got %b want 0", a_if.out_valid); else passed++;
   endtask

   task automatic fill_two();
      a_if.out_ready = 1'b0;
      a_if.mode      = 2'b00;
      a_if.in_valid  = 1'b1;
      a_if.imm       = 16'h0011;
      tick();
      a_if.imm = 16'h0022;
      tick();
      a_if.in_valid = 1'b0;
   endtask

   task automatic test_flush();
      fill_two();
      checks++; if (a_if.in_ready !== 1'b0) $display("FAIL fl_two: got in_ready %b want 0", a_if.in_ready); else passed++;
      a_if.in_valid = 1'b1;
      a_if.imm      = 16'h0033;
      a_if.flush    = 1'b1;
      tick();
      a_if.flush    = 1'b0;
      a_if.in_valid = 1'b0;
      a_if.out_ready = 1'b1;
      checks++; if (a_if.out_valid !== 1'b0 || a_if.in_ready !== 1'b1)
         $display("FAIL fl_empty: got v=%b r=%b want v=0 r=1", a_if.out_valid, a_if.in_ready);
      else passed++;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if (a_if.out_valid !== 1'b0) $display("FAIL fl_quiet%0d: got %b want 0", i, a_if.out_valid); else passed++;
      end
      // Flush from ONE with a same-cycle offer that in_ready would accept.
      a_if.out_ready = 1'b0;
      a_if.in_valid  = 1'b1;
      a_if.imm       = 16'h0044;
      tick();
      a_if.imm   = 16'h0055;
      a_if.flush = 1'b1;
      checks++; if (a_if.in_ready !== 1'b1) $display("FAIL fl_one_ready: got %b want 1", a_if.in_ready); else passed++;
      tick();
      a_if.flush    = 1'b0;
      a_if.in_valid = 1'b0;
      a_if.out_ready = 1'b1;
      checks++; if (a_if.out_valid !== 1'b0) $display("FAIL fl_one_drop: got %b want 0", a_if.out_valid); else passed++;
      tick();
      checks++; if (a_if.out_valid !== 1'b0) $display("FAIL fl_one_quiet: got %b want 0", a_if.out_valid); else passed++;
   endtask

   task automatic test_async_reset();
      fill_two();
      checks++; if (a_if.out_valid !== 1'b1 || a_if.out_imm !== 32'h11)
         $display("FAIL ar_pre: got v=%b %h want v=1 11", a_if.out_valid, a_if.out_imm);
      else passed++;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++; if (a_if.out_valid !== 1'b0 || a_if.out_imm !== 32'h0 || a_if.in_ready !== 1'b1)
         $display("FAIL ar_now: got v=%b r=%b %h want v=0 r=1 0", a_if.out_valid, a_if.in_ready, a_if.out_imm);
      else passed++;
      tick();
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      checks++; if (a_if.in_ready !== 1'b1 || a_if.out_valid !== 1'b0)
         $display("FAIL ar_rel: got r=%b v=%b want r=1 v=0", a_if.in_ready, a_if.out_valid);
      else passed++;
   endtask

   function automatic logic [19:0] ref12(input logic [11:0] im, input logic [1:0] md);
      int v;
      v = int'(im);
      if (md != 2'b00 && v >= 2048) v = v - 4096;
      case (md)
         2'b00:   return 20'(v);
         2'b01:   return 20'(v);
         2'b10:   return 20'(int'(im) * 256);
         default: return 20'(v * 4);
      endcase
   endfunction

   task automatic test_random();
      logic [19:0] q[$];
      logic [19:0] exp;
      int sent = 0;
      int got  = 0;
      int cyc  = 0;
      b_if.flush = 1'b0;
      while ((sent < 200 || got < sent) && cyc < 5000) begin
         b_if.in_valid  = (sent < 200) && ($urandom_range(0, 3) != 0);
         b_if.imm       = 12'($urandom);
         b_if.mode      = 2'($urandom);
         b_if.out_ready = ($urandom_range(0, 2) != 0);
         @(negedge clk);
         if (b_if.in_valid && b_if.in_ready) begin
            q.push_back(ref12(b_if.imm, b_if.mode));
            sent++;
         end
         if (b_if.out_valid && b_if.out_ready) begin
            checks++;
            if (q.size() == 0) begin
               $display("FAIL rnd_extra: got %h want no output", b_if.out_imm);
            end else begin
               exp = q.pop_front();
               if (b_if.out_imm !== exp) $display("FAIL rnd%0d: got %h want %h", got, b_if.out_imm, exp);
               else passed++;
            end
            got++;
         end
         tick();
         cyc++;
      end
      b_if.in_valid = 1'b0;
      checks++; if (sent != 200 || got != sent)
         $display("FAIL rnd_count: got sent=%0d out=%0d want 200/200", sent, got);
      else passed++;
   endtask

   initial begin
      a_if.in_valid = 1'b0; a_if.imm = '0; a_if.mode = '0; a_if.flush = 1'b0; a_if.out_ready = 1'b0;
      b_if.in_valid = 1'b0; b_if.imm = '0; b_if.mode = '0; b_if.flush = 1'b0; b_if.out_ready = 1'b0;
      test_reset();
      test_modes();
      test_back_to_back();
      test_backpressure();
      test_flush();
      test_async_reset();
      test_random();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
